xhat_prev_band_feeder: RTL and testbench



---
 rtl/xhat_prev_band_feeder_pkg.sv | 29 ++
 rtl/xhat_feeder_skid.sv | 67 ++++++
 rtl/xhat_prev_band_feeder.sv | 196 +++++++++++++++++++
 tb/tb_xhat_prev_band_feeder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xhat_prev_band_feeder_pkg.sv
// ============================================================================
// Module      : xhat_prev_band_feeder_pkg
// Description : Shared bank-state encoding and block-size helper for the
//               previous-band feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xhat_prev_band_feeder_pkg;

    localparam logic [1:0] c_BANK_EMPTY    = 2'd0;
    localparam logic [1:0] c_BANK_FILLING  = 2'd1;
    localparam logic [1:0] c_BANK_FULL     = 2'd2;
    localparam logic [1:0] c_BANK_DRAINING = 2'd3;

    typedef enum logic [1:0] {
        BANK_EMPTY    = c_BANK_EMPTY,
        BANK_FILLING  = c_BANK_FILLING,
        BANK_FULL     = c_BANK_FULL,
        BANK_DRAINING = c_BANK_DRAINING
    } bank_state_t;

    function automatic int unsigned block_size(input int unsigned log2_size);
        return 32'd1 << log2_size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xhat_feeder_skid.sv
// ============================================================================
// Module      : xhat_feeder_skid
// Description : Two-entry output skid buffer; head entry drives the outputs
//               directly so data holds steady while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xhat_feeder_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    // The producer meters pushes against o_count; a push into a full
    // buffer is only taken when a pop frees a slot in the same cycle.
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_valid && ((r_cnt != 2'd2) || w_pop);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/xhat_prev_band_feeder.sv
// ============================================================================
// Module      : xhat_prev_band_feeder
// Description : Ping-pong buffer of one band-block of xhat samples plus mean,
//               replayed to the predictor as the previous band.
//               Optional block counters: define XHAT_PREV_FEEDER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xhat_prev_band_feeder
    import xhat_prev_band_feeder_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xhat_data,
    input  logic                  xhat_valid,
    output logic                  xhat_ready,
    input  logic [DATA_WIDTH-1:0] xhatmean_data,
    input  logic                  xhatmean_valid,
    output logic                  xhatmean_ready,
    output logic [DATA_WIDTH-1:0] prev_data,
    output logic [DATA_WIDTH-1:0] prev_mean,
    output logic                  prev_last,
    output logic                  prev_valid,
    input  logic                  prev_ready
`ifdef XHAT_PREV_FEEDER_STATS_EN
    ,
    output logic [31:0]           blocks_in,
    output logic [31:0]           blocks_out
`endif
);

    localparam int unsigned c_DEPTH  = block_size(BLOCK_SIZE_LOG);
    localparam int          c_SKID_W = 2 * DATA_WIDTH + 1;
    localparam logic [BLOCK_SIZE_LOG-1:0] c_CNT_MAX = {BLOCK_SIZE_LOG{1'b1}};

    bank_state_t               r_state [2];
    logic                      r_en;
    logic                      r_wbank;
    logic                      r_rbank;
    logic                      r_drain_bank;
    logic [BLOCK_SIZE_LOG-1:0] r_wcnt;
    logic [BLOCK_SIZE_LOG-1:0] r_rcnt;
    logic                      r_samples_done;
    logic                      r_mean_done;
    logic [DATA_WIDTH-1:0]     r_mem [0:2*c_DEPTH-1];
    logic [DATA_WIDTH-1:0]     r_mean [2];

    logic                      r_rd_valid;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic [DATA_WIDTH-1:0]     r_rd_mean;
    logic                      r_rd_last;

    logic                      w_wr_open;
    logic                      w_acc_s;
    logic                      w_acc_m;
    logic                      w_last_s;
    logic                      w_fill_done;
    bank_state_t               w_rd_state;
    logic                      w_rd_avail;
    logic                      w_rd_last_addr;
    logic                      w_pop;
    logic                      w_drained;
    logic                      w_issue;
    logic [1:0]                w_skid_cnt;
    logic [1:0]                w_occ;
    logic [c_SKID_W-1:0]       w_skid_out;

    // ---------------- write side ----------------
    assign w_wr_open      = r_en && ((r_state[r_wbank] == BANK_EMPTY) ||
                                     (r_state[r_wbank] == BANK_FILLING));
    assign xhat_ready     = w_wr_open && !r_samples_done;
    assign xhatmean_ready = w_wr_open && !r_mean_done;
    assign w_acc_s        = xhat_valid && xhat_ready;
    assign w_acc_m        = xhatmean_valid && xhatmean_ready;
    assign w_last_s       = w_acc_s && (r_wcnt == c_CNT_MAX);
    assign w_fill_done    = (r_samples_done || w_last_s) && (r_mean_done || w_acc_m);

    // ---------------- read side ----------------
    // A bank is readable when freshly FULL, or mid-replay (rcnt wraps to 0
    // once every address of the bank has been issued).
    assign w_rd_state     = r_state[r_rbank];
    assign w_rd_avail     = (w_rd_state == BANK_FULL) ||
                            ((w_rd_state == BANK_DRAINING) && (r_rcnt != '0));
    assign w_rd_last_addr = (r_rcnt == c_CNT_MAX);
    assign w_pop          = prev_valid && prev_ready;
    assign w_drained      = w_pop && prev_last;

    // Skid slots plus the word in flight out of the RAM never exceed two.
    assign w_occ   = w_skid_cnt + {1'b0, r_rd_valid};
    assign w_issue = w_rd_avail && ((w_occ < 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (w_acc_s) r_mem[{r_wbank, r_wcnt}] <= xhat_data;
        if (w_issue) r_rd_data <= r_mem[{r_rbank, r_rcnt}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en           <= 1'b0;
            r_wbank        <= 1'b0;
            r_rbank        <= 1'b0;
            r_drain_bank   <= 1'b0;
            r_wcnt         <= '0;
            r_rcnt         <= '0;
            r_samples_done <= 1'b0;
            r_mean_done    <= 1'b0;
            r_mean[0]      <= '0;
            r_mean[1]      <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_mean      <= '0;
            r_rd_last      <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (w_acc_s) r_wcnt <= r_wcnt + 1'b1;
            if (w_acc_m) r_mean[r_wbank] <= xhatmean_data;
            if (w_fill_done) begin
                r_wbank        <= ~r_wbank;
                r_samples_done <= 1'b0;
                r_mean_done    <= 1'b0;
            end else begin
                if (w_last_s) r_samples_done <= 1'b1;
                if (w_acc_m)  r_mean_done    <= 1'b1;
            end

            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rcnt    <= r_rcnt + 1'b1;
                r_rd_mean <= r_mean[r_rbank];
                r_rd_last <= w_rd_last_addr;
                if (w_rd_last_addr) r_rbank <= ~r_rbank;
            end
            if (w_drained) r_drain_bank <= ~r_drain_bank;
        end
    end

    // Banks drain strictly in fill order, so r_drain_bank names the bank
    // that owns the prev_last currently at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                case (r_state[b])
                    BANK_EMPTY, BANK_FILLING: begin
                        if (r_wbank == 1'(b)) begin
                            if (w_fill_done)             r_state[b] <= BANK_FULL;
                            else if (w_acc_s || w_acc_m) r_state[b] <= BANK_FILLING;
                        end
                    end
                    BANK_FULL: begin
                        if ((r_rbank == 1'(b)) && w_issue) r_state[b] <= BANK_DRAINING;
                    end
                    BANK_DRAINING: begin
                        if ((r_drain_bank == 1'(b)) && w_drained) r_state[b] <= BANK_EMPTY;
                    end
                    default: r_state[b] <= BANK_EMPTY;
                endcase
            end
        end
    end

    xhat_feeder_skid #(
        .WIDTH (c_SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_rd_valid),
        .i_data  ({r_rd_last, r_rd_mean, r_rd_data}),
        .o_valid (prev_valid),
        .i_ready (prev_ready),
        .o_data  (w_skid_out),
        .o_count (w_skid_cnt)
    );

    assign {prev_last, prev_mean, prev_data} = w_skid_out;

`ifdef XHAT_PREV_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_in  <= 32'd0;
            blocks_out <= 32'd0;
        end else begin
            if (w_fill_done) blocks_in  <= blocks_in + 32'd1;
            if (w_drained)   blocks_out <= blocks_out + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xhat_prev_band_feeder.sv
// ============================================================================
// Module      : tb_xhat_prev_band_feeder
// Description : Self-checking bench for xhat_prev_band_feeder (4-sample blocks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xhat_prev_band_feeder;

    localparam int DW  = 16;
    localparam int BSL = 2;
    localparam int BLK = 1 << BSL;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        logic          l;
    } out_t;

    typedef struct packed {
        logic [BLK-1:0][DW-1:0] s;
        logic [DW-1:0]          mean;
        logic                   mean_first;
        logic [BLK-1:0][DW-1:0] exp_d;
        logic [DW-1:0]          exp_m;
    } vec_t;

    logic          clk            = 1'b0;
    logic          rst            = 1'b1;
    logic [DW-1:0] xhat_data      = '0;
    logic          xhat_valid     = 1'b0;
    logic          xhat_ready;
    logic [DW-1:0] xhatmean_data  = '0;
    logic          xhatmean_valid = 1'b0;
    logic          xhatmean_ready;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] prev_mean;
    logic          prev_last;
    logic          prev_valid;
    logic          prev_ready     = 1'b0;

    int   vectors     = 0;
    int   miscompares = 0;
    out_t exp_q[$];
    logic [DW-1:0] tx_q[$];
    bit   model_en   = 1'b0;
    bit   ready_mode = 1'b0;
    logic ready_fix  = 1'b0;

    logic [DW-1:0] cur_s[$];
    logic [DW-1:0] cur_m;
    bit            cur_m_got = 1'b0;
    bit            stall_prev = 1'b0;
    out_t          held;
    out_t          mon_e;
    out_t          mdl_e;

    xhat_prev_band_feeder #(
        .DATA_WIDTH     (DW),
        .BLOCK_SIZE_LOG (BSL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .xhat_data      (xhat_data),
        .xhat_valid     (xhat_valid),
        .xhat_ready     (xhat_ready),
        .xhatmean_data  (xhatmean_data),
        .xhatmean_valid (xhatmean_valid),
        .xhatmean_ready (xhatmean_ready),
        .prev_data      (prev_data),
        .prev_mean      (prev_mean),
        .prev_last      (prev_last),
        .prev_valid     (prev_valid),
        .prev_ready     (prev_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Consumer stall pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            prev_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Reference model: every accepted block (4 samples + its mean, in any
    // order) must come back in order, unchanged, with last on the 4th sample.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            cur_s.delete();
            cur_m_got = 1'b0;
        end else begin
            if (model_en) begin
                if (xhat_valid && xhat_ready) cur_s.push_back(xhat_data);
                if (xhatmean_valid && xhatmean_ready) begin
                    cur_m     = xhatmean_data;
                    cur_m_got = 1'b1;
                end
                if (cur_s.size() == BLK && cur_m_got) begin
                    for (int k = 0; k < BLK; k++) begin
                        mdl_e.d = cur_s[k];
                        mdl_e.m = cur_m;
                        mdl_e.l = (k == BLK - 1);
                        exp_q.push_back(mdl_e);
                    end
                    cur_s.delete();
                    cur_m_got = 1'b0;
                end
            end
            if (stall_prev)
                check("hold_while_stalled", 64'({prev_valid, prev_last, prev_mean, prev_data}),
                      64'({1'b1, held.l, held.m, held.d}));
            if (prev_valid && prev_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got data %0h mean %0h, expected no output",
                             prev_data, prev_mean);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("prev_out{last,mean,data}", 64'({prev_last, prev_mean, prev_data}),
                          64'({mon_e.l, mon_e.m, mon_e.d}));
                end
            end
            stall_prev = prev_valid && !prev_ready;
            held.d = prev_data;
            held.m = prev_mean;
            held.l = prev_last;
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_stream(input int n, output int cycles);
        int  i;
        bit  acc;
        i = 0;
        cycles = 0;
        xhat_valid = 1'b1;
        xhat_data  = tx_q[0];
        while (i < n) begin
            @(negedge clk);
            acc = xhat_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                i++;
                if (i < n) xhat_data = tx_q[i];
            end
            if (cycles > 500) begin
                fail_now("xhat_accept_timeout");
                break;
            end
        end
        xhat_valid = 1'b0;
    endtask

    task automatic send_mean(input logic [DW-1:0] m, output int cycles);
        bit acc;
        cycles = 0;
        acc = 1'b0;
        xhatmean_valid = 1'b1;
        xhatmean_data  = m;
        while (!acc) begin
            @(negedge clk);
            acc = xhatmean_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (cycles > 500) begin
                fail_now("mean_accept_timeout");
                break;
            end
        end
        xhatmean_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !prev_valid) done = 1'b1;
        end
        if (!done) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (xhat_ready) break;
        end
        check("ready_after_reset", 64'(xhat_ready), 64'(1'b1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_xhat_ready",     64'(xhat_ready),     64'(1'b0));
        check("rst_xhatmean_ready", 64'(xhatmean_ready), 64'(1'b0));
        check("rst_prev_valid",     64'(prev_valid),     64'(1'b0));
        check("rst_prev_last",      64'(prev_last),      64'(1'b0));
        check("rst_prev_data",      64'(prev_data),      64'(0));
        check("rst_prev_mean",      64'(prev_mean),      64'(0));
    endtask

    vec_t tbl [3];
    int   cyc, cyc_a, cyc_b, lat, run, dly;
    out_t e;

    initial begin
        tbl[0] = '{s: {16'd4, 16'd3, 16'd2, 16'd1}, mean: 16'd10, mean_first: 1'b0,
                   exp_d: {16'd4, 16'd3, 16'd2, 16'd1}, exp_m: 16'd10};
        tbl[1] = '{s: {16'd8, 16'd7, 16'd6, 16'd5}, mean: 16'd7, mean_first: 1'b1,
                   exp_d: {16'd8, 16'd7, 16'd6, 16'd5}, exp_m: 16'd7};
        tbl[2] = '{s: {16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF}, mean: 16'hFFFF, mean_first: 1'b0,
                   exp_d: {16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF}, exp_m: 16'hFFFF};

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready();

        // Directed table: single blocks, consumer always ready
        ready_fix = 1'b1;
        model_en  = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) begin
            tx_q.delete();
            for (int k = 0; k < BLK; k++) begin
                e.d = tbl[r].exp_d[k];
                e.m = tbl[r].exp_m;
                e.l = (k == BLK - 1);
                exp_q.push_back(e);
                tx_q.push_back(tbl[r].s[k]);
            end
            if (tbl[r].mean_first) begin
                send_mean(tbl[r].mean, cyc);
                check("mean_first_accept_cycles", 64'(cyc), 64'(1));
                send_stream(BLK, cyc);
            end else begin
                send_stream(BLK, cyc);
                send_mean(tbl[r].mean, cyc);
            end
            lat = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                lat++;
                if (prev_valid) break;
            end
            check("first_valid_latency", 64'(lat), 64'(3));
            wait_drain();
        end

        // Consumer stalled: two blocks fill both banks, third must wait
        model_en  = 1'b1;
        ready_fix = 1'b0;
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            tx_q.delete();
            for (int k = 0; k < BLK; k++) tx_q.push_back(16'(21 + 4 * b + k));
            send_stream(BLK, cyc);
            send_mean(16'(31 + b), cyc);
        end
        repeat (3) @(negedge clk);
        check("both_full_xhat_ready",     64'(xhat_ready),     64'(1'b0));
        check("both_full_xhatmean_ready", 64'(xhatmean_ready), 64'(1'b0));
        check("both_full_prev_valid",     64'(prev_valid),     64'(1'b1));
        @(posedge clk);
        #1;
        tx_q.delete();
        for (int k = 0; k < BLK; k++) tx_q.push_back(16'(29 + k));
        fork
            begin
                send_stream(BLK, cyc_a);
                send_mean(16'd33, cyc_a);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                ready_fix = 1'b1;
            end
        join
        wait_drain();

        // Back-to-back blocks replayed with no bubble at the bank boundary
        ready_fix = 1'b0;
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            tx_q.delete();
            for (int k = 0; k < BLK; k++) tx_q.push_back(16'(1 + 4 * b + k));
            send_stream(BLK, cyc);
            send_mean(16'(2 + 4 * b), cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        ready_fix = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (prev_ready) break;
        end
        run = 0;
        while (prev_valid && prev_ready && run < 20) begin
            run++;
            @(negedge clk);
        end
        check("back_to_back_run", 64'(run), 64'(2 * BLK));
        @(posedge clk);
        #1;
        wait_drain();

        // Random data, random mean timing, random consumer stalls
        ready_mode = 1'b1;
        for (int b = 0; b < 12; b++) begin
            tx_q.delete();
            for (int k = 0; k < BLK; k++) tx_q.push_back(16'($urandom));
            dly = $urandom_range(0, 6);
            fork
                send_stream(BLK, cyc_a);
                begin
                    if (dly > 0) begin
                        repeat (dly) @(posedge clk);
                        #1;
                    end
                    send_mean(16'($urandom), cyc_b);
                end
            join
        end
        ready_mode = 1'b0;
        ready_fix  = 1'b1;
        wait_drain();

        // Reset in the middle of a block discards the partial data
        model_en = 1'b0;
        tx_q.delete();
        tx_q.push_back(16'd41);
        tx_q.push_back(16'd42);
        send_stream(2, cyc);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready();
        tx_q.delete();
        for (int k = 0; k < BLK; k++) begin
            e.d = 16'(9 + k);
            e.m = 16'd3;
            e.l = (k == BLK - 1);
            exp_q.push_back(e);
            tx_q.push_back(16'(9 + k));
        end
        send_stream(BLK, cyc);
        send_mean(16'd3, cyc);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
